// File: rtl/mem_arbiter.sv
// Purpose : shares one word-wide main-memory port between icache (port 0) and dcache (port 1).
// Latency : accept at edge E, one-cycle resp_valid pulse in the cycle after edge E+MEM_LATENCY.
// Backpres: req_ready only in IDLE for the selected valid port; others hold until accepted.
//
// Ports:
//   i_clk, i_reset      rising-edge clock, asynchronous active-low reset
//   i_req_valid/_write  per-port request strobe and direction (1 = write)
//   i_req_addr/_wdata   per-port word address and write data (bits 31:24 = byte 0)
//   o_req_ready         per-port acceptance (combinational, IDLE only)
//   o_resp_valid        per-port one-cycle completion pulse
//   o_resp_rdata        read word, 0 for writes
//   o_mem_address       memory address (holds last value outside ACCESS)
//   o_mem_data_in       memory write bytes, [0] = bits 31:24
//   o_mem_write_en      memory write strobe, high only during ACCESS of a write
//   i_mem_data_out      memory read bytes, [0] = bits 31:24
module mem_arbiter #(
  parameter int MEM_LATENCY   = 3,
  parameter int PRIORITY_MODE = 0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [1:0]       i_req_valid,
  input  logic [1:0]       i_req_write,
  input  logic [1:0][31:0] i_req_addr,
  input  logic [1:0][31:0] i_req_wdata,
  output logic [1:0]       o_req_ready,
  output logic [1:0]       o_resp_valid,
  output logic [31:0]      o_resp_rdata,
  output logic [31:0]      o_mem_address,
  output logic [0:3][7:0]  o_mem_data_in,
  output logic             o_mem_write_en,
  input  logic [0:3][7:0]  i_mem_data_out
);

  localparam int CW = $clog2(MEM_LATENCY + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic            r_last_grant;
  logic            r_gnt;
  logic            r_write;
  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;
  logic [31:0]     r_rdata;
  logic            w_sel;
  logic            w_accept;

  // Port selection. With both ports pending, round-robin picks the port that
  // was not granted last; fixed mode always favours the dcache.
  always_comb begin
    w_sel = 1'b0;
    if (i_req_valid == 2'b11) begin
      w_sel = (PRIORITY_MODE == 1) ? 1'b1 : ~r_last_grant;
    end else if (i_req_valid[1]) begin
      w_sel = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next         = r_state;
    w_accept       = 1'b0;
    o_req_ready    = 2'b00;
    o_resp_valid   = 2'b00;
    o_mem_write_en = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_req_valid[w_sel]) begin
          o_req_ready[w_sel] = 1'b1;
          w_accept           = 1'b1;
          w_next             = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        o_mem_write_en = r_write;
        if (r_cnt == '0) begin
          w_next = ST_RESP;
        end
      end
      ST_RESP: begin
        o_resp_valid[r_gnt] = 1'b1;
        w_next              = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Request latch, access counter and response capture. The counter is only
  // reloaded on acceptance and parks at zero, so it never wraps.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt        <= '0;
      r_last_grant <= 1'b1;
      r_gnt        <= 1'b0;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
    end else begin
      if (w_accept) begin
        r_cnt        <= CW'(MEM_LATENCY - 1);
        r_last_grant <= w_sel;
        r_gnt        <= w_sel;
        r_write      <= i_req_write[w_sel];
        r_addr       <= i_req_addr[w_sel];
        r_wdata      <= i_req_wdata[w_sel];
      end
      if (r_state == ST_ACCESS) begin
        if (r_cnt == '0) begin
          r_rdata <= r_write ? 32'd0 : 32'(i_mem_data_out);
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
      end
    end
  end

  assign o_mem_address = r_addr;
  assign o_mem_data_in = r_wdata;
  assign o_resp_rdata  = r_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose : directed checks of mem_arbiter in round-robin (u_rr) and fixed-priority (u_fx) modes.
// Latency : memory model is combinational on the address; DUT latency is MEM_LATENCY=3.
// Backpres: requesters hold req_* until accepted, as the arbiter expects.
module tb_mem_arbiter;

  logic clk;
  logic reset;

  logic [1:0]       a_valid, a_write, a_ready, a_resp;
  logic [1:0][31:0] a_addr, a_wdata;
  logic [31:0]      a_rdata, a_maddr;
  logic [0:3][7:0]  a_mdin, a_mdout;
  logic             a_mwe;

  logic [1:0]       b_valid, b_write, b_ready, b_resp;
  logic [1:0][31:0] b_addr, b_wdata;
  logic [31:0]      b_rdata, b_maddr;
  logic [0:3][7:0]  b_mdin, b_mdout;
  logic             b_mwe;

  int n_asserts = 0;
  int n_fail    = 0;

  function automatic logic [31:0] mem_model(input logic [31:0] addr);
    if (addr == 32'h0000_1000) return 32'hDEAD_BEEF;
    return {addr[15:0], ~addr[15:0]};
  endfunction

  assign a_mdout = mem_model(a_maddr);
  assign b_mdout = mem_model(b_maddr);

  mem_arbiter #(.MEM_LATENCY(3), .PRIORITY_MODE(0)) u_rr (
    .i_clk(clk), .i_reset(reset),
    .i_req_valid(a_valid), .i_req_write(a_write),
    .i_req_addr(a_addr), .i_req_wdata(a_wdata),
    .o_req_ready(a_ready), .o_resp_valid(a_resp), .o_resp_rdata(a_rdata),
    .o_mem_address(a_maddr), .o_mem_data_in(a_mdin), .o_mem_write_en(a_mwe),
    .i_mem_data_out(a_mdout)
  );

  mem_arbiter #(.MEM_LATENCY(3), .PRIORITY_MODE(1)) u_fx (
    .i_clk(clk), .i_reset(reset),
    .i_req_valid(b_valid), .i_req_write(b_write),
    .i_req_addr(b_addr), .i_req_wdata(b_wdata),
    .o_req_ready(b_ready), .o_resp_valid(b_resp), .o_resp_rdata(b_rdata),
    .o_mem_address(b_maddr), .o_mem_data_in(b_mdin), .o_mem_write_en(b_mwe),
    .i_mem_data_out(b_mdout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wcnt;
    int resp_at;
    int got;
    int bad;
    int last_c;
    logic [1:0] exp_v;

    reset   = 1'b0;
    a_valid = '0; a_write = '0; a_addr = '0; a_wdata = '0;
    b_valid = '0; b_write = '0; b_addr = '0; b_wdata = '0;

    // Reset state
    #12;
    check("rst_ready",   32'(a_ready), 32'd0);
    check("rst_resp",    32'(a_resp),  32'd0);
    check("rst_mwe",     32'(a_mwe),   32'd0);
    check("rst_maddr",   a_maddr,      32'd0);
    check("rst_mdin",    32'(a_mdin),  32'd0);
    check("rst_rdata",   a_rdata,      32'd0);
    check("rst_b_resp",  32'(b_resp),  32'd0);
    @(posedge clk);
    #2 reset = 1'b1;

    // Port 0 read of 0x1000
    a_valid = 2'b01; a_write = 2'b00; a_addr[0] = 32'h0000_1000;
    #1;
    check("rd_ready_accept", 32'(a_ready), 32'h1);
    tick();
    a_valid = 2'b00;
    check("rd_ready_busy", 32'(a_ready), 32'h0);
    check("rd_maddr",      a_maddr,      32'h0000_1000);
    check("rd_mwe",        32'(a_mwe),   32'h0);
    tick();
    tick();
    check("rd_resp_early", 32'(a_resp),  32'h0);
    tick();
    check("rd_resp",       32'(a_resp),  32'h1);
    check("rd_rdata",      a_rdata,      32'hDEAD_BEEF);
    tick();
    check("rd_resp_pulse", 32'(a_resp),  32'h0);

    // Port 1 write of 0x12345678 to 0x2004
    a_valid = 2'b10; a_write = 2'b10;
    a_addr[1] = 32'h0000_2004; a_wdata[1] = 32'h1234_5678;
    #1;
    check("wr_ready_accept", 32'(a_ready), 32'h2);
    tick();
    a_valid = 2'b00;
    wcnt = 0;
    resp_at = -1;
    for (int c = 1; c <= 10; c++) begin
      if (a_resp != 2'b00) begin
        resp_at = c;
        break;
      end
      if (a_mwe) begin
        wcnt++;
        check("wr_mdin", 32'(a_mdin), 32'h1234_5678);
      end
      tick();
    end
    check("wr_mwe_cycles", 32'(wcnt),    32'd3);
    check("wr_resp_cycle", 32'(resp_at), 32'd4);
    check("wr_resp",       32'(a_resp),  32'h2);
    check("wr_rdata",      a_rdata,      32'h0);
    check("wr_mwe_resp",   32'(a_mwe),   32'h0);
    check("wr_maddr",      a_maddr,      32'h0000_2004);
    tick();

    // Reset asserted in the middle of a write access
    a_valid = 2'b01; a_write = 2'b01;
    a_addr[0] = 32'h0000_3000; a_wdata[0] = 32'hCAFE_F00D;
    tick();
    a_valid = 2'b00;
    tick();
    check("mid_mwe_before", 32'(a_mwe), 32'h1);
    #2 reset = 1'b0;
    #1;
    check("mid_mwe_reset",   32'(a_mwe),  32'h0);
    check("mid_maddr_reset", a_maddr,     32'h0);
    check("mid_resp_reset",  32'(a_resp), 32'h0);
    #2 reset = 1'b1;
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (a_resp != 2'b00) bad++;
    end
    check("mid_no_resp", 32'(bad), 32'd0);

    // Round-robin with both ports requesting continuously
    a_valid = 2'b11; a_write = 2'b00;
    a_addr[0] = 32'h0000_0100; a_addr[1] = 32'h0000_0200;
    got = 0;
    last_c = -1;
    for (int c = 0; c < 40 && got < 4; c++) begin
      tick();
      if (a_resp != 2'b00) begin
        exp_v = (got % 2 == 0) ? 2'b01 : 2'b10;
        check("rr_grant", 32'(a_resp), 32'(exp_v));
        check("rr_data",  a_rdata, mem_model(a_addr[(got % 2 == 0) ? 0 : 1]));
        if (last_c >= 0) check("rr_spacing", 32'(c - last_c), 32'd5);
        last_c = c;
        got++;
      end
    end
    a_valid = 2'b00;
    check("rr_count", 32'(got), 32'd4);
    tick();
    tick();

    // Fixed priority: dcache wins until it drops its request
    b_valid = 2'b11; b_write = 2'b00;
    b_addr[0] = 32'h0000_0400; b_addr[1] = 32'h0000_0500;
    #1;
    check("fx_ready_both", 32'(b_ready), 32'h2);
    got = 0;
    for (int c = 0; c < 60 && got < 4; c++) begin
      tick();
      if (b_resp != 2'b00) begin
        exp_v = (got < 3) ? 2'b10 : 2'b01;
        check("fx_grant", 32'(b_resp), 32'(exp_v));
        check("fx_data",  b_rdata, mem_model(b_addr[(got < 3) ? 1 : 0]));
        got++;
        if (got == 3) b_valid = 2'b01;
      end
    end
    b_valid = 2'b00;
    check("fx_count", 32'(got), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
